// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath constants (ALU control codes, aluop classes, R-type functs).
package mips_pkg;
  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 5;
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_RTYPE = 2'b10,
    AOP_PASS  = 2'b11
  } aluop_e;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: aluop/funct to 4-bit ALU control; unknown R-type functs fall back to add and raise illegal.
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] aluctrl,
  output logic       illegal
);
  always_comb begin
    aluctrl = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      AOP_SUB:  aluctrl = ALU_SUB;
      AOP_PASS: aluctrl = ALU_PASS;
      AOP_RTYPE:
        case (funct)
          F_ADD, F_ADDU: aluctrl = ALU_ADD;
          F_SUB, F_SUBU: aluctrl = ALU_SUB;
          F_AND:         aluctrl = ALU_AND;
          F_OR:          aluctrl = ALU_OR;
          F_NOR:         aluctrl = ALU_NOR;
          default:       illegal = 1'b1;
        endcase
      default: aluctrl = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, ALU control decode, load-use stall and flush.
// ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding; without it operands come from the register file and any RAW stalls.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [DW-1:0] imm,
  input  logic          use_imm,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic [1:0]    aluop,
  input  logic [5:0]    funct,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          flush,
  input  logic          exm_rw,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_rw,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  input  logic          ex_ready,
  output logic          out_valid,
  output logic [DW-1:0] d1_out,
  output logic [DW-1:0] d2_out,
  output logic [3:0]    aluctrl_out,
  output logic [RW-1:0] rd_out,
  output logic          reg_write_out,
  output logic          mem_read_out,
  output logic          mem_write_out,
  output logic          illegal_funct,
  output logic          load_use_stall
);
  logic          valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, ill_q, ill_d;
  logic [DW-1:0] d1_q, d1_d, d2_q, d2_d, rs_fwd, rt_fwd;
  logic [3:0]    ctrl_q, ctrl_d, dec_ctrl;
  logic [RW-1:0] rd_q, rd_d;
  logic          dec_ill, accept;
  alu_ctrl_dec u_dec (.aluop(aluop), .funct(funct), .aluctrl(dec_ctrl), .illegal(dec_ill));
`ifdef ID_EX_FWD_EN
  logic exm_rs, exm_rt, mwb_rs, mwb_rt;
  assign exm_rs = exm_rw & (exm_rd != '0) & (exm_rd == rs_addr);
  assign exm_rt = exm_rw & (exm_rd != '0) & (exm_rd == rt_addr);
  assign mwb_rs = mwb_rw & (mwb_rd != '0) & (mwb_rd == rs_addr);
  assign mwb_rt = mwb_rw & (mwb_rd != '0) & (mwb_rd == rt_addr);
  assign rs_fwd = exm_rs ? exm_data : mwb_rs ? mwb_data : rs_data;
  assign rt_fwd = exm_rt ? exm_data : mwb_rt ? mwb_data : rt_data;
  assign load_use_stall = in_valid & valid_q & mr_q & (rd_q != '0) &
                          ((rd_q == rs_addr) | (!use_imm & (rd_q == rt_addr)));
`else
  logic raw_rs, raw_rt, unused_fwd;
  assign unused_fwd = ^{exm_data, mwb_data};
  assign rs_fwd = rs_data;
  assign rt_fwd = rt_data;
  // Without bypass paths every in-flight writer must retire before a dependent read.
  assign raw_rs = (rs_addr != '0) & ((valid_q & rw_q & (rd_q == rs_addr)) |
                  (exm_rw & (exm_rd == rs_addr)) | (mwb_rw & (mwb_rd == rs_addr)));
  assign raw_rt = (rt_addr != '0) & ((valid_q & rw_q & (rd_q == rt_addr)) |
                  (exm_rw & (exm_rd == rt_addr)) | (mwb_rw & (mwb_rd == rt_addr)));
  assign load_use_stall = in_valid & (raw_rs | (!use_imm & raw_rt));
`endif
  assign in_ready = !flush & !load_use_stall & (!valid_q | ex_ready);
  assign accept   = in_valid & in_ready;
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : ex_ready ? 1'b0 : valid_q;
    rw_d    = flush ? 1'b0 : accept ? reg_write : rw_q;
    mr_d    = flush ? 1'b0 : accept ? mem_read : mr_q;
    mw_d    = flush ? 1'b0 : accept ? mem_write : mw_q;
    d1_d    = accept ? rs_fwd : d1_q;
    d2_d    = accept ? (use_imm ? imm : rt_fwd) : d2_q;
    ctrl_d  = accept ? dec_ctrl : ctrl_q;
    ill_d   = accept ? dec_ill : ill_q;
    rd_d    = accept ? rd_addr : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ill_q   <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      ill_q   <= ill_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
    end
  end
  assign out_valid     = valid_q;
  assign reg_write_out = rw_q;
  assign mem_read_out  = mr_q;
  assign mem_write_out = mw_q;
  assign illegal_funct = ill_q;
  assign d1_out        = d1_q;
  assign d2_out        = d2_q;
  assign aluctrl_out   = ctrl_q;
  assign rd_out        = rd_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table plus corner-case sequences for id_ex_stage (both ID_EX_FWD_EN builds).
module tb_id_ex_stage;
  import mips_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid, in_ready, use_imm, reg_write, mem_read, mem_write, flush;
  logic [31:0] rs_data, rt_data, imm, exm_data, mwb_data, d1_out, d2_out;
  logic [4:0]  rs_addr, rt_addr, rd_addr, exm_rd, mwb_rd, rd_out;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic        exm_rw, mwb_rw, ex_ready, out_valid;
  logic [3:0]  aluctrl_out;
  logic        reg_write_out, mem_read_out, mem_write_out, illegal_funct, load_use_stall;
  int errors = 0, checks = 0;

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        use_imm;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic        rw, mr, mw;
    logic [3:0]  e_ctrl;
    logic        e_ill;
  } vec_t;
  vec_t tab[12];

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .use_imm(use_imm),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .aluop(aluop), .funct(funct),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .exm_rw(exm_rw), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_rw(mwb_rw), .mwb_rd(mwb_rd), .mwb_data(mwb_data), .ex_ready(ex_ready),
    .out_valid(out_valid), .d1_out(d1_out), .d2_out(d2_out), .aluctrl_out(aluctrl_out),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .illegal_funct(illegal_funct), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] f, input logic ui,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                              input logic rw, input logic mr, input logic mw,
                              input logic [3:0] ec, input logic ei);
    vec_t v;
    v.aluop = op; v.funct = f; v.use_imm = ui; v.rs_d = a; v.rt_d = b; v.imm = im;
    v.rs_a = 5'd1; v.rt_a = 5'd2; v.rd_a = 5'd20;
    v.rw = rw; v.mr = mr; v.mw = mw; v.e_ctrl = ec; v.e_ill = ei;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    aluop = v.aluop; funct = v.funct; use_imm = v.use_imm;
    rs_data = v.rs_d; rt_data = v.rt_d; imm = v.imm;
    rs_addr = v.rs_a; rt_addr = v.rt_a; rd_addr = v.rd_a;
    reg_write = v.rw; mem_read = v.mr; mem_write = v.mw;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    tab[0]  = mk(2'b00, 6'd0,      1'b1, 32'h100,      32'h999,      32'h10,   1, 0, 0, ALU_ADD,  0);
    tab[1]  = mk(2'b01, 6'd0,      1'b0, 32'h50,       32'h20,       32'h0,    1, 0, 0, ALU_SUB,  0);
    tab[2]  = mk(2'b11, 6'd0,      1'b1, 32'h0,        32'h0,        32'hCAFE, 1, 0, 0, ALU_PASS, 0);
    tab[3]  = mk(2'b10, 6'b100000, 1'b0, 32'h1,        32'h2,        32'h0,    1, 0, 0, ALU_ADD,  0);
    tab[4]  = mk(2'b10, 6'b100001, 1'b0, 32'h3,        32'h4,        32'h0,    1, 0, 0, ALU_ADD,  0);
    tab[5]  = mk(2'b10, 6'b100010, 1'b0, 32'h5,        32'h6,        32'h0,    1, 1, 0, ALU_SUB,  0);
    tab[6]  = mk(2'b10, 6'b100011, 1'b0, 32'h7,        32'h8,        32'h0,    0, 0, 1, ALU_SUB,  0);
    tab[7]  = mk(2'b10, 6'b100100, 1'b0, 32'hFF00,     32'h0FF0,     32'h0,    1, 0, 0, ALU_AND,  0);
    tab[8]  = mk(2'b10, 6'b100101, 1'b0, 32'hA,        32'h5,        32'h0,    1, 0, 0, ALU_OR,   0);
    tab[9]  = mk(2'b10, 6'b100111, 1'b0, 32'h0F0F0000, 32'h00F0000F, 32'h0,    1, 0, 0, ALU_NOR,  0);
    tab[10] = mk(2'b10, 6'b101010, 1'b0, 32'h11,       32'h22,       32'h0,    1, 0, 0, ALU_ADD,  1);
    tab[11] = mk(2'b10, 6'b100000, 1'b0, 32'h33,       32'h44,       32'h0,    1, 0, 0, ALU_ADD,  0);
    in_valid = 0; flush = 0; ex_ready = 1;
    exm_rw = 0; exm_rd = 0; exm_data = 0; mwb_rw = 0; mwb_rd = 0; mwb_data = 0;
    drive(tab[0]);
    #12;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset aluctrl", 32'(aluctrl_out), 0);
    chk("reset illegal", 32'(illegal_funct), 0);
    chk("reset d1", d1_out, 0);
    chk("reset reg_write", 32'(reg_write_out), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int i = 0; i < 12; i++) begin
      v = tab[i];
      v.rd_a = 5'(20 + i);
      drive(v);
      in_valid = 1;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 1);
      step();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d aluctrl", i), 32'(aluctrl_out), 32'(v.e_ctrl));
      chk($sformatf("v%0d illegal", i), 32'(illegal_funct), 32'(v.e_ill));
      chk($sformatf("v%0d d1", i), d1_out, v.rs_d);
      chk($sformatf("v%0d d2", i), d2_out, v.use_imm ? v.imm : v.rt_d);
      chk($sformatf("v%0d rd", i), 32'(rd_out), 32'(v.rd_a));
      chk($sformatf("v%0d ctl", i), 32'({reg_write_out, mem_read_out, mem_write_out}),
          32'({v.rw, v.mr, v.mw}));
    end
    in_valid = 0;
    step();
    chk("drain out_valid", 32'(out_valid), 0);

    // forwarding priority and register-0 exclusion
    v = mk(2'b00, 6'd0, 1'b0, 32'hAAAA, 32'hBBBB, 32'h0, 1, 0, 0, ALU_ADD, 0);
    v.rs_a = 5'd5; v.rt_a = 5'd6; v.rd_a = 5'd7;
    drive(v);
    exm_rw = 1; exm_rd = 5; exm_data = 32'h11;
    mwb_rw = 1; mwb_rd = 5; mwb_data = 32'h22;
    in_valid = 1;
    #1;
`ifdef ID_EX_FWD_EN
    step();
    chk("fwd exm over mwb", d1_out, 32'h11);
    exm_rw = 0; mwb_rd = 6;
    #1;
    step();
    chk("fwd mwb rs none", d1_out, 32'hAAAA);
    chk("fwd mwb rt", d2_out, 32'h22);
`else
    chk("raw stall exm", 32'(load_use_stall), 1);
    chk("raw in_ready", 32'(in_ready), 0);
`endif
    rs_addr = 0; rt_addr = 0; exm_rw = 1; exm_rd = 0; mwb_rw = 1; mwb_rd = 0;
    #1;
    chk("r0 no stall", 32'(load_use_stall), 0);
    step();
    chk("r0 no fwd d1", d1_out, 32'hAAAA);
    chk("r0 no fwd d2", d2_out, 32'hBBBB);
    exm_rw = 0; mwb_rw = 0; in_valid = 0;
    step();

    // load-use: lw r8 held, dependent add waits one cycle
    v = mk(2'b00, 6'd0, 1'b1, 32'h1000, 32'h0, 32'h4, 1, 1, 0, ALU_ADD, 0);
    v.rd_a = 5'd8;
    drive(v);
    in_valid = 1;
    step();
    v = mk(2'b10, 6'b100000, 1'b0, 32'h123, 32'h5, 32'h0, 1, 0, 0, ALU_ADD, 0);
    v.rs_a = 5'd8; v.rd_a = 5'd9;
    drive(v);
    #1;
    chk("lu stall", 32'(load_use_stall), 1);
    chk("lu in_ready", 32'(in_ready), 0);
    step();
    chk("lu bubble", 32'(out_valid), 0);
`ifdef ID_EX_FWD_EN
    exm_rw = 1; exm_rd = 8; exm_data = 32'h88;
`endif
    #1;
    chk("lu released", 32'(load_use_stall), 0);
    chk("lu in_ready2", 32'(in_ready), 1);
    step();
    chk("lu add valid", 32'(out_valid), 1);
    chk("lu add rd", 32'(rd_out), 9);
`ifdef ID_EX_FWD_EN
    chk("lu add d1", d1_out, 32'h88);
`else
    chk("lu add d1", d1_out, 32'h123);
`endif
    exm_rw = 0; in_valid = 0;
    step();

    // backpressure then flush
    v = mk(2'b01, 6'd0, 1'b0, 32'h55, 32'h66, 32'h0, 1, 0, 1, ALU_SUB, 0);
    v.rd_a = 5'd10;
    drive(v);
    in_valid = 1;
    step();
    v = mk(2'b00, 6'd0, 1'b1, 32'h77, 32'h0, 32'h1, 1, 1, 0, ALU_ADD, 0);
    v.rs_a = 5'd3; v.rd_a = 5'd11;
    drive(v);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 0);
      step();
      chk($sformatf("bp%0d valid", i), 32'(out_valid), 1);
      chk($sformatf("bp%0d d1", i), d1_out, 32'h55);
      chk($sformatf("bp%0d aluctrl", i), 32'(aluctrl_out), 32'(ALU_SUB));
      chk($sformatf("bp%0d rd", i), 32'(rd_out), 10);
    end
    flush = 1;
    #1;
    chk("flush in_ready", 32'(in_ready), 0);
    step();
    chk("flush valid", 32'(out_valid), 0);
    chk("flush ctl", 32'({reg_write_out, mem_read_out, mem_write_out}), 0);
    flush = 0; in_valid = 0; ex_ready = 1;
    step();

    // async reset while stalled
    v = mk(2'b10, 6'b101010, 1'b0, 32'hDEAD, 32'h1, 32'h0, 1, 0, 0, ALU_ADD, 1);
    v.rd_a = 5'd12;
    drive(v);
    in_valid = 1;
    step();
    chk("pre-rst illegal", 32'(illegal_funct), 1);
    ex_ready = 0;
    v = mk(2'b00, 6'd0, 1'b1, 32'h9, 32'h0, 32'h2, 1, 0, 0, ALU_ADD, 0);
    v.rd_a = 5'd13;
    drive(v);
    step();
    chk("pre-rst in_ready", 32'(in_ready), 0);
    rst_n = 0;
    #1;
    chk("rst valid", 32'(out_valid), 0);
    chk("rst illegal", 32'(illegal_funct), 0);
    chk("rst aluctrl", 32'(aluctrl_out), 0);
    chk("rst d1", d1_out, 0);
    chk("rst reg_write", 32'(reg_write_out), 0);
    #1;
    rst_n = 1;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 1);
    step();
    chk("post-rst accept", 32'(out_valid), 1);
    chk("post-rst d2", d2_out, 32'h2);
    in_valid = 0; ex_ready = 1;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the MIPS datapath, sitting directly upstream of the execution ALU.
- Accepts decoded instructions from ID and forwards operands from the EX/MEM and MEM/WB result buses.
- Generates the 4-bit ALU control code and registers d1/d2/aluctrl plus control bits for EX.
- Detects load-use hazards and supports stall (valid/ready) and flush.

Parameters:
- DW, 32, datapath width
- RW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID holds a decoded instruction
- in_ready  out  1  stage accepts this cycle
- rs_data, rt_data  in  DW  register file read data
- imm  in  DW  sign/zero-extended immediate
- use_imm  in  1  d2 source: 1=imm, 0=rt
- rs_addr, rt_addr, rd_addr  in  RW  source/destination registers
- aluop  in  2  main-decoder ALU class
- funct  in  6  R-type function field
- reg_write, mem_read, mem_write  in  1  control bits
- flush  in  1  squash stage contents (branch/jump)
- exm_rw, exm_rd, exm_data  in  1/RW/DW  EX/MEM result
- mwb_rw, mwb_rd, mwb_data  in  1/RW/DW  MEM/WB result
- ex_ready  in  1  EX consumes output this cycle
- out_valid  out  1  registered contents valid
- d1_out, d2_out  out  DW  ALU operands
- aluctrl_out  out  4  ALU control
- rd_out  out  RW  destination
- reg_write_out, mem_read_out, mem_write_out  out  1  registered control bits
- illegal_funct  out  1  registered, R-type funct not decoded
- load_use_stall  out  1  combinational hazard indicator

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including out_valid, aluctrl_out and illegal_funct.
- Single-entry register, 1-cycle latency from accept to out_valid.
- Hazard: load_use_stall = in_valid & out_valid & mem_read_out & (rd_out!=0) & ((rd_out==rs_addr) | (!use_imm & rd_out==rt_addr)).
- in_ready = !flush & !load_use_stall & (!out_valid | ex_ready).
- Accept (in_valid & in_ready): capture forwarded operands, decoded aluctrl and control bits; out_valid=1 next cycle.
- No accept & ex_ready: out_valid=0 next cycle; data registers hold.
- Not ex_ready & out_valid: all outputs hold stable.
- Flush: out_valid=0, reg_write_out/mem_read_out/mem_write_out=0 next cycle; flush has priority over everything except reset.
- Forwarding per source operand, priority EX/MEM > MEM/WB > register file. Match requires rw=1 and rd==addr, and never for register 0.
- d2 = use_imm ? imm : forwarded rt.
- aluctrl decode:
  - aluop 00 -> 0010
  - aluop 01 -> 0110
  - aluop 11 -> 0111 (pass d2)
  - aluop 10 by funct: 100000/100001 -> 0010; 100010/100011 -> 0110; 100100 -> 0000; 100101 -> 0001; 100111 -> 1100; other -> 0010 with illegal_funct=1.
- Reset asserted mid-stall: outputs clear immediately; in_ready reflects the reset state (out_valid=0) once rst_n releases.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding as above; load_use_stall as above.
- Undefined: no forwarding muxes; operands taken directly from rs_data/rt_data. load_use_stall widens to any RAW match (nonzero addr) against (out_valid & reg_write_out & rd_out) or (exm_rw & exm_rd) or (mwb_rw & mwb_rd).

Decomposition:
- Shared package mips_pkg:
  - ALU control constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASS=0111, ALU_NOR=1100
  - aluop encodings
  - funct codes
  - DW/RW defaults
- One sub-module, alu_ctrl_dec: combinational aluop/funct -> aluctrl, illegal flag.

Test Plan:
- Reset mid-stall: with out_valid=1, pull rst_n low between clock edges -> all outputs 0 immediately; in_ready=1 after release with in_valid high.
- R-type funct 100111, rs_data=0x0F0F0000, rt_data=0x00F0000F -> next cycle aluctrl_out=1100, d1/d2 equal inputs, out_valid=1.
- Forwarding priority: rs_addr=5, exm_rd=5 data 0x11, mwb_rd=5 data 0x22, both rw=1 -> d1_out=0x11. Same with exm_rd=0 and mwb_rd=0 -> d1_out=rs_data.
- Load-use: stage holds lw rd=8; new add with rs=8 -> load_use_stall=1, in_ready=0 for one cycle; the add enters the following cycle.
- Backpressure and flush: ex_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then flush=1 -> out_valid=0 and write bits 0 next cycle.
- funct 101010 with aluop 10 -> aluctrl_out=0010, illegal_funct=1. Next legal instruction -> illegal_funct=0.
